// File: rtl/seq_pkg.sv
// Shared encodings for the multi-cycle sequencer: state codes and the
// opcodes the sequencer itself recognises.
package seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam logic [5:0] OP_HALT = 6'b111111;
    localparam logic [5:0] OP_NOP  = 6'b111110;

endpackage

// File: rtl/seq_wait_timer.sv
// Saturating 8-bit wait counter; expired flags the cycle where the
// count has reached the programmed limit.
module seq_wait_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       tick,
    input  logic [7:0] limit,
    output logic       expired
);

    logic [7:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear)
            wait_cnt <= 8'd0;
        else if (tick && wait_cnt != 8'hFF)
            wait_cnt <= wait_cnt + 8'd1;
    end

    assign expired = (wait_cnt == limit);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshake
// timeout, sticky halt/fault stop states and a retired-instruction counter.
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               halt,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic               RegWrite,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    output logic               imem_req,
    output logic               ir_load,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic               reg_wr_en,
    output logic               pc_write,
    output logic               halted,
    output logic               fault,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   instr_count
);

    state_t cur, nxt;
    logic   tick, expired, is_halt;
    logic   imem_req_c, ir_load_c, dmem_req_c, dmem_we_c, reg_wr_en_c, pc_write_c;

    assign is_halt = halt || (opcode == OP_HALT);

    always_ff @(posedge clk) begin
        if (reset) cur <= S_FETCH;
        else       cur <= nxt;
    end

    always_comb begin
        nxt         = cur;
        tick        = 1'b0;
        imem_req_c  = 1'b0;
        ir_load_c   = 1'b0;
        dmem_req_c  = 1'b0;
        dmem_we_c   = 1'b0;
        reg_wr_en_c = 1'b0;
        pc_write_c  = 1'b0;
        case (cur)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ready) begin
                    ir_load_c = 1'b1;
                    nxt       = S_DECODE;
                end else if (expired) begin
                    nxt = S_FAULT;
                end else begin
                    tick = 1'b1;
                end
            end
            S_DECODE: nxt = is_halt ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (MemRead || MemWrite) nxt = S_MEM;
                else if (RegWrite)       nxt = S_WB;
                else begin
                    pc_write_c = 1'b1;
                    nxt        = S_FETCH;
                end
            end
            S_MEM: begin
                // Both flags set is illegal and handled as a load.
                dmem_req_c = 1'b1;
                dmem_we_c  = MemWrite && !MemRead;
                if (dmem_ready) begin
                    if (MemRead) nxt = S_WB;
                    else begin
                        pc_write_c = 1'b1;
                        nxt        = S_FETCH;
                    end
                end else if (expired) begin
                    nxt = S_FAULT;
                end else begin
                    tick = 1'b1;
                end
            end
            S_WB: begin
                reg_wr_en_c = 1'b1;
                pc_write_c  = 1'b1;
                nxt         = S_FETCH;
            end
            S_HALT:  nxt = S_HALT;
            S_FAULT: nxt = S_FAULT;
            default: nxt = S_FETCH;
        endcase
    end

    seq_wait_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (nxt != cur),
        .tick    (tick),
        .limit   (8'(MEM_TIMEOUT)),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset)         instr_count <= '0;
        else if (pc_write) instr_count <= instr_count + 1'b1;
    end

    // Everything visible is held low while reset is asserted.
    assign imem_req  = !reset && imem_req_c;
    assign ir_load   = !reset && ir_load_c;
    assign dmem_req  = !reset && dmem_req_c;
    assign dmem_we   = !reset && dmem_we_c;
    assign reg_wr_en = !reset && reg_wr_en_c;
    assign pc_write  = !reset && pc_write_c;
    assign halted    = !reset && (cur == S_HALT);
    assign fault     = !reset && (cur == S_FAULT);
    assign state     = reset ? STATE_W'(S_FETCH) : cur;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer; expectations are hand-computed
// cycle by cycle from the sequencing rules.
module tb_multicycle_sequencer;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [5:0]       opcode;
    logic             halt, MemRead, MemWrite, RegWrite, imem_ready, dmem_ready;
    logic             imem_req, ir_load, dmem_req, dmem_we, reg_wr_en, pc_write;
    logic             halted, fault;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_count;

    int n_chk  = 0;
    int n_fail = 0;

    multicycle_sequencer #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .halt(halt),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .reg_wr_en(reg_wr_en), .pc_write(pc_write),
        .halted(halted), .fault(fault), .state(state), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock; sample point is 2 time units after the edge.
    task automatic nxt;
        @(posedge clk);
        #2;
    endtask

    task automatic flags(input logic h, input logic mr, input logic mw, input logic rw);
        halt = h; MemRead = mr; MemWrite = mw; RegWrite = rw;
        opcode = h ? 6'b111111 : 6'b111110;
    endtask

    initial begin
        reset = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
        flags(0, 0, 0, 1);
        repeat (2) nxt();
        #1;
        chk("rst_state",   32'(state), 0);
        chk("rst_imemreq", 32'(imem_req), 0);
        chk("rst_irload",  32'(ir_load), 0);
        chk("rst_count",   32'(instr_count), 0);

        // ALU instruction, zero-wait
        reset = 1'b0; #1;
        chk("alu_f_state", 32'(state), 0);
        chk("alu_f_req",   32'(imem_req), 1);
        chk("alu_f_irld",  32'(ir_load), 1);
        nxt(); chk("alu_d_state", 32'(state), 1);
        chk("alu_d_irld", 32'(ir_load), 0);
        nxt(); chk("alu_e_state", 32'(state), 2);
        chk("alu_e_pcw", 32'(pc_write), 0);
        nxt(); chk("alu_w_state", 32'(state), 4);
        chk("alu_w_regwr", 32'(reg_wr_en), 1);
        chk("alu_w_pcw",   32'(pc_write), 1);
        nxt(); chk("alu_done_state", 32'(state), 0);
        chk("alu_count", 32'(instr_count), 1);

        // lw with three dmem wait cycles
        flags(0, 1, 0, 1); dmem_ready = 1'b0;
        nxt(); chk("lw_d", 32'(state), 1);
        nxt(); chk("lw_e", 32'(state), 2);
        for (int i = 0; i < 3; i++) begin
            nxt();
            chk("lw_mwait_state", 32'(state), 3);
            chk("lw_mwait_req",   32'(dmem_req), 1);
            chk("lw_mwait_we",    32'(dmem_we), 0);
            chk("lw_mwait_pcw",   32'(pc_write), 0);
        end
        nxt(); dmem_ready = 1'b1; #1;
        chk("lw_mlast_state", 32'(state), 3);
        chk("lw_mlast_pcw",   32'(pc_write), 0);
        nxt(); chk("lw_w_state", 32'(state), 4);
        chk("lw_w_regwr", 32'(reg_wr_en), 1);
        chk("lw_w_pcw",   32'(pc_write), 1);
        nxt(); chk("lw_done", 32'(state), 0);
        chk("lw_count", 32'(instr_count), 2);

        // sw, zero-wait
        flags(0, 0, 1, 0);
        nxt(); nxt(); nxt();
        chk("sw_m_state", 32'(state), 3);
        chk("sw_m_req",   32'(dmem_req), 1);
        chk("sw_m_we",    32'(dmem_we), 1);
        chk("sw_m_regwr", 32'(reg_wr_en), 0);
        chk("sw_m_pcw",   32'(pc_write), 1);
        nxt(); chk("sw_done", 32'(state), 0);
        chk("sw_count", 32'(instr_count), 3);

        // halt: two cycles to HALT, then inert
        flags(1, 0, 0, 0);
        nxt(); chk("halt_d", 32'(state), 1);
        nxt(); chk("halt_state", 32'(state), 5);
        chk("halt_flag", 32'(halted), 1);
        for (int i = 0; i < 20; i++) begin
            imem_ready = ~imem_ready;
            nxt();
        end
        chk("halt_hold_state", 32'(state), 5);
        chk("halt_hold_req",   32'(imem_req), 0);
        chk("halt_hold_count", 32'(instr_count), 3);
        chk("halt_hold_flag",  32'(halted), 1);

        // fetch timeout: 16 FETCH cycles then FAULT
        reset = 1'b1; imem_ready = 1'b0; flags(0, 0, 0, 0);
        nxt(); reset = 1'b0; #1;
        chk("to_halted_clr", 32'(halted), 0);
        for (int i = 0; i < 15; i++) nxt();
        chk("to_last_fetch", 32'(state), 0);
        chk("to_last_req",   32'(imem_req), 1);
        nxt(); chk("to_fault_state", 32'(state), 6);
        chk("to_fault_flag", 32'(fault), 1);
        chk("to_fault_req",  32'(imem_req), 0);

        // ready exactly at the limit cycle wins
        reset = 1'b1;
        nxt(); reset = 1'b0; #1;
        chk("to2_fault_clr", 32'(fault), 0);
        for (int i = 0; i < 15; i++) nxt();
        imem_ready = 1'b1; #1;
        chk("to2_irld", 32'(ir_load), 1);
        flags(0, 1, 0, 1); dmem_ready = 1'b0;
        nxt(); chk("to2_decode", 32'(state), 1);
        chk("to2_nofault", 32'(fault), 0);

        // reset mid-MEM of a lw
        nxt(); nxt();
        chk("rm_mem", 32'(state), 3);
        reset = 1'b1; #1;
        chk("rm_rst_state", 32'(state), 0);
        chk("rm_rst_dreq",  32'(dmem_req), 0);
        nxt();
        chk("rm_next_state", 32'(state), 0);
        chk("rm_next_regwr", 32'(reg_wr_en), 0);
        chk("rm_next_count", 32'(instr_count), 0);

        // counter wrap with NOPs
        flags(0, 0, 0, 0); imem_ready = 1'b1; dmem_ready = 1'b1;
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            nxt(); nxt(); nxt();
        end
        chk("wrap_max", 32'(instr_count), 15);
        nxt(); nxt(); nxt();
        chk("wrap_zero",  32'(instr_count), 0);
        chk("wrap_state", 32'(state), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
